mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 172 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit bridging core byte accesses onto a 32-bit word memory with an ack timeout.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned H/W accesses give an error response instead of being force-aligned.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [13:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_we;
  logic [13:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [2:0]  r_funct3;
  logic [1:0]  r_boff;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;

  logic [1:0]  w_size;
  logic        w_illegal;
  logic [15:0] w_addr_al;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_size = req_funct3[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
  logic w_misaligned;
  assign w_misaligned = ((w_size == 2'b01) && req_addr[0]) ||
                        ((w_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                     (req_funct3 == 3'b111) || w_misaligned;
  assign w_addr_al = req_addr;
`else
  assign w_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                     (req_funct3 == 3'b111);
  // Halfwords drop bit 0, words drop bits 1:0; byte accesses keep the full address.
  assign w_addr_al = {req_addr[15:2], req_addr[1] & ~w_size[1],
                      req_addr[0] & (w_size == 2'b00)};
`endif

  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = 32'h0000_0000;
    if (req_write) begin
      case (w_size)
        2'b00: begin
          w_wstrb = 4'b0001 << w_addr_al[1:0];
          w_wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          w_wstrb = w_addr_al[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          w_wstrb = 4'b1111;
          w_wdata = req_wdata;
        end
      endcase
    end
  end

  always_comb begin
    case (r_boff)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_boff[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'h0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_we        <= 1'b0;
      r_addr      <= 14'd0;
      r_wdata     <= 32'h0;
      r_wstrb     <= 4'b0000;
      r_funct3    <= 3'b000;
      r_boff      <= 2'b00;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (w_illegal) begin
              r_state     <= S_DONE;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= 32'h0;
            end else begin
              r_state  <= S_ACCESS;
              r_cnt    <= 8'd0;
              r_we     <= req_write;
              r_addr   <= w_addr_al[15:2];
              r_wdata  <= w_wdata;
              r_wstrb  <= w_wstrb;
              r_funct3 <= req_funct3;
              r_boff   <= w_addr_al[1:0];
            end
          end
        end
        S_ACCESS: begin
          if (mem_ack) begin
            r_state     <= S_DONE;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= r_we ? 32'h0 : w_load;
          end else if (r_cnt == TO_LAST) begin
            r_state     <= S_DONE;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= 32'h0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall     = ((r_state == S_IDLE) && req_valid) || (r_state == S_ACCESS);
  assign mem_req   = (r_state == S_ACCESS);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wstrb = r_wstrb;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases then random loads/stores against a reference model.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: RISC-V access rules computed with plain arithmetic.
  function automatic bit is_legal(input logic [2:0] f3, input logic [15:0] a);
    int sz;
    int off;
    sz  = int'(f3) % 4;
    off = int'(a) % 4;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    if (sz == 1 && (off % 2) != 0) return 1'b0;
    if (sz == 2 && off != 0) return 1'b0;
`else
    if (sz < 0 || off < 0) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic [15:0] eff_addr(input logic [2:0] f3, input logic [15:0] a);
    int sz;
    sz = int'(f3) % 4;
    if (sz == 1) return a & 16'hFFFE;
    if (sz == 2) return a & 16'hFFFC;
    return a;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [15:0] a, input logic [31:0] w);
    logic [31:0] s;
    logic [31:0] v;
    s = w >> (8 * (int'(a) % 4));
    case (f3)
      3'd0: begin v = s % 256;   return (v >= 128)   ? v + 32'hFFFF_FF00 : v; end
      3'd4: return s % 256;
      3'd1: begin v = s % 65536; return (v >= 32768) ? v + 32'hFFFF_0000 : v; end
      3'd5: return s % 65536;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] exp_strb(input logic [2:0] f3, input logic wr, input logic [15:0] a);
    int sz;
    sz = int'(f3) % 4;
    if (!wr) return 32'd0;
    if (sz == 0) return 32'd1 << (int'(a) % 4);
    if (sz == 1) return 32'd3 << (int'(a) % 4);
    return 32'd15;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int sz;
    sz = int'(f3) % 4;
    if (sz == 0) return (wd % 256) * 32'h0101_0101;
    if (sz == 1) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  // One request: ack_at = ACCESS cycle index carrying the ack (<0 never).
  task automatic run_req(input string tag, input logic [2:0] f3, input logic wr,
                         input logic [15:0] a, input logic [31:0] wd, input int ack_at,
                         input logic [31:0] rd, input bit late_ack, input bit hold_in_done);
    bit          ok;
    bit          acked;
    int          n_acc;
    logic [15:0] ae;
    logic [13:0] exp_maddr;
    logic [31:0] exp_rd;
    logic        exp_err;
    ok        = is_legal(f3, a);
    ae        = eff_addr(f3, a);
    exp_maddr = ae[15:2];
    acked     = (ack_at >= 0) && (ack_at < TO);
    req_valid = 1'b1; req_funct3 = f3; req_write = wr; req_addr = a; req_wdata = wd;
    #1;
    chk({tag, " stall_req"}, 32'(stall), 32'd1);
    @(negedge clk);
    req_valid = (!ok) && hold_in_done;
    req_wdata = $urandom;
    #1;
    if (ok) begin
      n_acc = acked ? ack_at + 1 : TO;
      for (int c = 0; c < n_acc; c++) begin
        chk({tag, " mem_req"}, 32'(mem_req), 32'd1);
        chk({tag, " rsp_valid_busy"}, 32'(rsp_valid), 32'd0);
        chk({tag, " stall_busy"}, 32'(stall), 32'd1);
        chk({tag, " mem_we"}, 32'(mem_we), 32'(wr));
        chk({tag, " mem_addr"}, 32'(mem_addr), 32'(exp_maddr));
        chk({tag, " mem_wstrb"}, 32'(mem_wstrb), exp_strb(f3, wr, ae));
        if (wr) chk({tag, " mem_wdata"}, mem_wdata, exp_wdata(f3, wd));
        mem_ack   = (c == ack_at);
        mem_rdata = (c == ack_at) ? rd : $urandom;
        if (c == n_acc - 1 && hold_in_done) req_valid = 1'b1;
        @(negedge clk);
      end
      mem_ack = 1'b0;
      exp_err = !acked;
      exp_rd  = (exp_err || wr) ? 32'd0 : exp_load(f3, ae, rd);
    end else begin
      exp_err = 1'b1;
      exp_rd  = 32'd0;
    end
    #1;
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
    chk({tag, " rsp_rdata"}, rsp_rdata, exp_rd);
    chk({tag, " mem_req_done"}, 32'(mem_req), 32'd0);
    chk({tag, " stall_done"}, 32'(stall), 32'd0);
    if (late_ack) begin mem_ack = 1'b1; mem_rdata = $urandom; end
    @(negedge clk);
    chk({tag, " rsp_valid_pulse"}, 32'(rsp_valid), 32'd0);
    chk({tag, " rsp_err_hold"}, 32'(rsp_err), 32'(exp_err));
    chk({tag, " rsp_rdata_hold"}, rsp_rdata, exp_rd);
    chk({tag, " mem_req_idle"}, 32'(mem_req), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0;
    chk({tag, " idle_quiet"}, {30'd0, mem_req, rsp_valid}, 32'd0);
    $display("txn %s f3=%0d we=%0b addr=%h ack_at=%0d rdata=%h err=%0b", tag, f3, wr, a, ack_at, rsp_rdata, rsp_err);
  endtask

  initial begin
    logic [2:0]  rf3;
    logic        rwr;
    logic [15:0] ra;
    logic [31:0] rwd;
    logic [31:0] rrd;
    int          rdly;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 16'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_req("lw_basic", 3'd2, 1'b0, 16'h0010, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    run_req("lb_neg",   3'd0, 1'b0, 16'h0013, 32'h0, 0, 32'h8011_2233, 1'b0, 1'b0);
    run_req("lbu",      3'd4, 1'b0, 16'h0013, 32'h0, 0, 32'h8011_2233, 1'b0, 1'b0);
    run_req("lhu",      3'd5, 1'b0, 16'h0012, 32'h0, 0, 32'h8011_2233, 1'b0, 1'b0);
    run_req("lh_neg",   3'd1, 1'b0, 16'h0000, 32'h0, 2, 32'h1234_9ABC, 1'b0, 1'b0);
    run_req("sb",       3'd0, 1'b1, 16'h0021, 32'h0000_00A5, 0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_req("sh_hi",    3'd1, 1'b1, 16'h0032, 32'h1234_5678, 1, 32'h0, 1'b0, 1'b0);
    run_req("sw_tmo",   3'd2, 1'b1, 16'h0040, 32'hCAFE_F00D, -1, 32'h0, 1'b1, 1'b0);
    run_req("ack_last", 3'd2, 1'b0, 16'h0044, 32'h0, TO - 1, 32'h0BAD_CAFE, 1'b0, 1'b0);
    run_req("lw_mis",   3'd2, 1'b0, 16'h0002, 32'h0, 0, 32'h5555_AAAA, 1'b0, 1'b0);
    run_req("ill_f3",   3'd3, 1'b0, 16'h0050, 32'h0, 0, 32'h0, 1'b1, 1'b1);
    run_req("done_req", 3'd4, 1'b0, 16'h0061, 32'h0, 0, 32'h00C3_0000, 1'b0, 1'b1);

    req_valid = 1'b1; req_funct3 = 3'd2; req_write = 1'b0; req_addr = 16'h0080;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_access mem_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_abort mem_req", 32'(mem_req), 32'd0);
    chk("rst_abort rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_abort rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_abort stall", 32'(stall), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_late_ack", {30'd0, mem_req, rsp_valid}, 32'd0);
    end
    mem_ack = 1'b0;
    $display("txn reset_abort done");

    for (int i = 0; i < 40; i++) begin
      rf3  = 3'($urandom_range(7, 0));
      rwr  = 1'($urandom_range(1, 0));
      ra   = 16'($urandom);
      rwd  = $urandom;
      rrd  = $urandom;
      rdly = int'($urandom_range(TO + 1, 0));
      run_req($sformatf("rnd%0d", i), rf3, rwr, ra, rwd, rdly, rrd, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
